// File: rtl/pipe_control_unit.sv
// pipe_control_unit: ID decoder + ID/EX control register; in: clk, reset, Opcode1/Funct1/Rs1/Rt1, IDEX_Rt, flush; out: stall, *_ex control bundle, ALUOp_ex, Illegal_ex, mult_busy
module pipe_control_unit #(
  parameter int ALUOP_W     = 4,
  parameter int REG_AW      = 5,
  parameter int MULT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Opcode1,
  input  logic [5:0]         Funct1,
  input  logic [REG_AW-1:0]  Rs1,
  input  logic [REG_AW-1:0]  Rt1,
  input  logic [REG_AW-1:0]  IDEX_Rt,
  input  logic               flush,
  output logic               stall,
  output logic               JtoPC_ex,
  output logic               Branch_ex,
  output logic               RegWrite_ex,
  output logic               RegDst_ex,
  output logic               ALUSrc_ex,
  output logic               MemWrite_ex,
  output logic               MemRead_ex,
  output logic               MemtoReg_ex,
  output logic [ALUOP_W-1:0] ALUOp_ex,
  output logic               Illegal_ex,
  output logic               mult_busy
);
  localparam int MW = $clog2(MULT_CYCLES) + 1;
  typedef struct packed {
    logic               j, b, rw, rd, as, mw, mr, mt, ill;
    logic [ALUOP_W-1:0] op;
  } ctl_t;
  ctl_t          ctl_d, ctl_q;
  logic          is_mult, load_use;
  logic [MW-1:0] mcnt_q;
  always_comb begin
    ctl_d   = '0;
    is_mult = 1'b0;
    case (Opcode1)
      6'b000000: begin
        case (Funct1)
          6'b000000: ctl_d.op = '0;
          6'b100000: ctl_d.op = ALUOP_W'(1);
          6'b100010: ctl_d.op = ALUOP_W'(2);
          6'b100100: ctl_d.op = ALUOP_W'(3);
          6'b100101: ctl_d.op = ALUOP_W'(4);
          6'b011000: ctl_d.op = ALUOP_W'(5);
          6'b100110: ctl_d.op = ALUOP_W'(6);
          6'b100111: ctl_d.op = ALUOP_W'(7);
          6'b101010: ctl_d.op = ALUOP_W'(8);
          default:   ctl_d.ill = 1'b1;
        endcase
        ctl_d.rw = ctl_d.op != '0;
        ctl_d.rd = ctl_d.op != '0;
        is_mult  = Funct1 == 6'b011000;
      end
      6'b000100: begin ctl_d.b = 1'b1; ctl_d.as = 1'b1; ctl_d.op = ALUOP_W'(9); end
      6'b000010: begin ctl_d.j = 1'b1; ctl_d.op = ALUOP_W'(10); end
      6'b100011: begin ctl_d.rw = 1'b1; ctl_d.as = 1'b1; ctl_d.mr = 1'b1; ctl_d.mt = 1'b1; ctl_d.op = ALUOP_W'(11); end
      6'b101011: begin ctl_d.as = 1'b1; ctl_d.mw = 1'b1; ctl_d.op = ALUOP_W'(12); end
      6'b001000: begin ctl_d.rw = 1'b1; ctl_d.as = 1'b1; ctl_d.op = ALUOP_W'(13); end
      6'b000101: begin ctl_d.b = 1'b1; ctl_d.as = 1'b1; ctl_d.op = ALUOP_W'(14); end
      default:   ctl_d.ill = 1'b1;
    endcase
  end
  assign load_use  = ctl_q.mr && IDEX_Rt != '0 && (IDEX_Rt == Rs1 || IDEX_Rt == Rt1);
  assign mult_busy = mcnt_q != '0;
  assign stall     = load_use | mult_busy;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ctl_q  <= '0;
      mcnt_q <= '0;
    end else if (mult_busy) begin
      mcnt_q <= mcnt_q - 1'b1;
    end else if (load_use) begin
      ctl_q <= '0;
    end else begin
      ctl_q  <= ctl_d;
      mcnt_q <= is_mult ? MW'(MULT_CYCLES - 1) : '0;
    end
  end
  assign {JtoPC_ex, Branch_ex, RegWrite_ex, RegDst_ex, ALUSrc_ex, MemWrite_ex,
          MemRead_ex, MemtoReg_ex, Illegal_ex, ALUOp_ex} = ctl_q;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed plus randomized checks of pipe_control_unit against a behavioural model
module tb_pipe_control_unit;
  localparam int AW = 4;
  localparam int RW = 5;
  localparam int MC = 3;
  logic          clk = 1'b0;
  logic          reset, flush;
  logic [5:0]    Opcode1, Funct1;
  logic [RW-1:0] Rs1, Rt1, IDEX_Rt;
  logic          stall, JtoPC_ex, Branch_ex, RegWrite_ex, RegDst_ex, ALUSrc_ex;
  logic          MemWrite_ex, MemRead_ex, MemtoReg_ex, Illegal_ex, mult_busy;
  logic [AW-1:0] ALUOp_ex;
  int nvec = 0;
  int nerr = 0;
  typedef struct packed {
    bit j, b, rw, rd, as, mw, mr, mt, ill, mult;
    int op;
  } ctl_t;
  ctl_t m_ex;
  int   m_rem;
  bit   known = 1'b0;
  pipe_control_unit #(.ALUOP_W(AW), .REG_AW(RW), .MULT_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .Opcode1(Opcode1), .Funct1(Funct1), .Rs1(Rs1), .Rt1(Rt1),
    .IDEX_Rt(IDEX_Rt), .flush(flush), .stall(stall), .JtoPC_ex(JtoPC_ex), .Branch_ex(Branch_ex),
    .RegWrite_ex(RegWrite_ex), .RegDst_ex(RegDst_ex), .ALUSrc_ex(ALUSrc_ex),
    .MemWrite_ex(MemWrite_ex), .MemRead_ex(MemRead_ex), .MemtoReg_ex(MemtoReg_ex),
    .ALUOp_ex(ALUOp_ex), .Illegal_ex(Illegal_ex), .mult_busy(mult_busy)
  );
  always #5 clk = ~clk;
  function automatic ctl_t decode(logic [5:0] op, logic [5:0] fn);
    ctl_t c;
    c = '0;
    if (op == 6'd0) begin
      case (fn)
        6'd32: c.op = 1;
        6'd34: c.op = 2;
        6'd36: c.op = 3;
        6'd37: c.op = 4;
        6'd24: c.op = 5;
        6'd38: c.op = 6;
        6'd39: c.op = 7;
        6'd42: c.op = 8;
        default: c.op = 0;
      endcase
      if (fn != 6'd0 && c.op == 0) c.ill = 1;
      if (c.op != 0) begin c.rw = 1; c.rd = 1; end
      c.mult = fn == 6'd24;
    end else begin
      case (op)
        6'd4:  begin c.b = 1; c.as = 1; c.op = 9; end
        6'd2:  begin c.j = 1; c.op = 10; end
        6'd35: begin c.rw = 1; c.as = 1; c.mr = 1; c.mt = 1; c.op = 11; end
        6'd43: begin c.as = 1; c.mw = 1; c.op = 12; end
        6'd8:  begin c.rw = 1; c.as = 1; c.op = 13; end
        6'd5:  begin c.b = 1; c.as = 1; c.op = 14; end
        default: c.ill = 1;
      endcase
    end
    return c;
  endfunction
  function automatic logic [8+AW:0] pack(ctl_t c);
    return {c.j, c.b, c.rw, c.rd, c.as, c.mw, c.mr, c.mt, c.ill, AW'(c.op)};
  endfunction
  function automatic bit m_lu();
    return m_ex.mr && IDEX_Rt != 0 && (IDEX_Rt == Rs1 || IDEX_Rt == Rt1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic id(input logic [5:0] op, input logic [5:0] fn, input logic [RW-1:0] rs,
                    input logic [RW-1:0] rt, input logic [RW-1:0] idex);
    Opcode1 = op; Funct1 = fn; Rs1 = rs; Rt1 = rt; IDEX_Rt = idex;
  endtask
  task automatic step();
    bit   lu;
    ctl_t d;
    #1;
    if (known) begin
      chk("stall", 32'(stall), 32'(m_lu() || m_rem > 0));
      chk("busy_pre", 32'(mult_busy), 32'(m_rem > 0));
    end
    lu = m_lu();
    d  = decode(Opcode1, Funct1);
    @(posedge clk);
    if (reset || flush) begin m_ex = '0; m_rem = 0; end
    else if (m_rem > 0) m_rem--;
    else if (lu) m_ex = '0;
    else begin m_ex = d; m_rem = d.mult ? MC - 1 : 0; end
    known = 1'b1;
    #1;
    chk("bundle", 32'({JtoPC_ex, Branch_ex, RegWrite_ex, RegDst_ex, ALUSrc_ex, MemWrite_ex,
                       MemRead_ex, MemtoReg_ex, Illegal_ex, ALUOp_ex}), 32'(pack(m_ex)));
    chk("busy_post", 32'(mult_busy), 32'(m_rem > 0));
  endtask
  logic [5:0] ops[7] = '{6'd0, 6'd4, 6'd2, 6'd35, 6'd43, 6'd8, 6'd5};
  logic [5:0] fns[9] = '{6'd0, 6'd32, 6'd34, 6'd36, 6'd37, 6'd24, 6'd38, 6'd39, 6'd42};
  initial begin
    reset = 1'b1; flush = 1'b0;
    id(6'd35, 6'd0, 5'd0, 5'd0, 5'd0);
    step();
    step();
    chk("rst_memread", 32'(MemRead_ex), 32'd0);
    chk("rst_aluop", 32'(ALUOp_ex), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(mult_busy), 32'd0);
    reset = 1'b0;
    step();
    chk("lw_memread", 32'(MemRead_ex), 32'd1);
    chk("lw_aluop", 32'(ALUOp_ex), 32'd11);
    id(6'd0, 6'd32, 5'd1, 5'd2, 5'd0);
    step();
    chk("add_aluop", 32'(ALUOp_ex), 32'd1);
    chk("add_regwrite", 32'(RegWrite_ex), 32'd1);
    chk("add_regdst", 32'(RegDst_ex), 32'd1);
    id(6'd43, 6'd0, 5'd1, 5'd2, 5'd0);
    step();
    chk("sw_aluop", 32'(ALUOp_ex), 32'd12);
    chk("sw_memwrite", 32'(MemWrite_ex), 32'd1);
    id(6'd35, 6'd0, 5'd0, 5'd5, 5'd0);
    step();
    id(6'd0, 6'd32, 5'd5, 5'd2, 5'd5);
    #1 chk("lu_stall", 32'(stall), 32'd1);
    step();
    chk("lu_bubble_op", 32'(ALUOp_ex), 32'd0);
    chk("lu_bubble_rw", 32'(RegWrite_ex), 32'd0);
    #1 chk("lu_stall_once", 32'(stall), 32'd0);
    step();
    chk("lu_after_op", 32'(ALUOp_ex), 32'd1);
    id(6'd35, 6'd0, 5'd0, 5'd0, 5'd0);
    step();
    id(6'd0, 6'd32, 5'd0, 5'd0, 5'd0);
    #1 chk("rt0_nostall", 32'(stall), 32'd0);
    step();
    chk("rt0_op", 32'(ALUOp_ex), 32'd1);
    id(6'd0, 6'd24, 5'd1, 5'd2, 5'd0);
    step();
    chk("mult_op1", 32'(ALUOp_ex), 32'd5);
    chk("mult_busy1", 32'(mult_busy), 32'd1);
    id(6'd0, 6'd32, 5'd1, 5'd2, 5'd0);
    #1 chk("mult_stall1", 32'(stall), 32'd1);
    step();
    chk("mult_op2", 32'(ALUOp_ex), 32'd5);
    chk("mult_busy2", 32'(mult_busy), 32'd1);
    step();
    chk("mult_op3", 32'(ALUOp_ex), 32'd5);
    chk("mult_busy3", 32'(mult_busy), 32'd0);
    step();
    chk("mult_next_op", 32'(ALUOp_ex), 32'd1);
    id(6'd0, 6'd24, 5'd1, 5'd2, 5'd0);
    step();
    flush = 1'b1;
    id(6'd0, 6'd32, 5'd1, 5'd2, 5'd0);
    step();
    flush = 1'b0;
    chk("flush_op", 32'(ALUOp_ex), 32'd0);
    chk("flush_busy", 32'(mult_busy), 32'd0);
    #1 chk("flush_stall", 32'(stall), 32'd0);
    id(6'd63, 6'd0, 5'd1, 5'd2, 5'd0);
    step();
    chk("ill_op_ill", 32'(Illegal_ex), 32'd1);
    chk("ill_op_rw", 32'(RegWrite_ex), 32'd0);
    chk("ill_op_alu", 32'(ALUOp_ex), 32'd0);
    id(6'd0, 6'd1, 5'd1, 5'd2, 5'd0);
    #1 chk("ill_nostall", 32'(stall), 32'd0);
    step();
    chk("ill_fn_ill", 32'(Illegal_ex), 32'd1);
    chk("ill_fn_rw", 32'(RegWrite_ex), 32'd0);
    chk("ill_fn_alu", 32'(ALUOp_ex), 32'd0);
    for (int i = 0; i < 400; i++) begin
      reset = $urandom % 32 == 0;
      flush = $urandom % 10 == 0;
      id($urandom % 8 == 0 ? 6'($urandom) : ops[$urandom % 7],
         $urandom % 8 == 0 ? 6'($urandom) : fns[$urandom % 9],
         RW'($urandom % 4), RW'($urandom % 4), RW'($urandom % 4));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
